// File: rtl/sr_pkg.sv
// Shared definitions for the status-register update path: SR bit layout,
// write masks, reset value, shadow stack sizing and request arbitration.
package sr_pkg;

  localparam int SR_C_BIT  = 0;
  localparam int SR_Z_BIT  = 1;
  localparam int SR_N_BIT  = 2;
  localparam int SR_V_BIT  = 3;
  localparam int SR_IE_BIT = 4;
  localparam int SR_S_BIT  = 5;

  localparam logic [7:0] SR_WR_MASK      = 8'h3F;
  localparam logic [7:0] SR_USER_WR_MASK = 8'h0F;
  localparam logic [7:0] SR_RESET_VAL    = 8'h20;

  localparam int STK_DEPTH = 4;
  localparam int STK_PTR_W = $clog2(STK_DEPTH);
  localparam int STK_CNT_W = STK_PTR_W + 1;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_IRQ_ENTER,
    REQ_IRQ_EXIT,
    REQ_WRITE,
    REQ_ALU
  } req_e;

  // Fixed priority: interrupt entry beats return beats explicit write beats ALU.
  function automatic req_e pick_req(input logic irq_enter, input logic irq_exit,
                                    input logic wr_en, input logic alu_valid);
    if (irq_enter)      return REQ_IRQ_ENTER;
    else if (irq_exit)  return REQ_IRQ_EXIT;
    else if (wr_en)     return REQ_WRITE;
    else if (alu_valid) return REQ_ALU;
    else                return REQ_NONE;
  endfunction

endpackage

// File: rtl/sr_shadow_stack.sv
// LIFO of saved status-register values used across nested interrupts.
// Overflowing pushes and underflowing pops are ignored; the caller flags them.
module sr_shadow_stack
  import sr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [7:0]           din,
  output logic [7:0]           top,
  output logic [STK_CNT_W-1:0] depth,
  output logic                 full,
  output logic                 empty
);

  logic [7:0]           mem [STK_DEPTH];
  logic [STK_CNT_W-1:0] cnt;
  logic [STK_PTR_W-1:0] wr_ptr;
  logic [STK_PTR_W-1:0] rd_ptr;

  assign wr_ptr = cnt[STK_PTR_W-1:0];
  assign rd_ptr = wr_ptr - STK_PTR_W'(1);
  assign full   = (cnt == STK_CNT_W'(STK_DEPTH));
  assign empty  = (cnt == '0);
  assign depth  = cnt;
  assign top    = mem[rd_ptr];

  // NOTE: only the occupancy count is reset; entries above it are unreachable,
  // so the storage needs no reset and can map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + STK_CNT_W'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - STK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push && !full) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/sr_update_ctrl.sv
// Computes the next status-register value from ALU, explicit-write and
// interrupt requests, and tracks sticky shadow-stack error flags.
module sr_update_ctrl
  import sr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sr_cur,
  input  logic       alu_valid,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_ovf,
  input  logic [3:0] flag_mask,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       irq_enter,
  input  logic       irq_exit,
  input  logic       err_clr,
  output logic [7:0] sr_next,
  output logic [2:0] stk_depth,
  output logic       stk_ovf,
  output logic       stk_unf
);

  req_e       req;
  logic       push;
  logic       pop;
  logic       ovf_set;
  logic       unf_set;
  logic       stk_full;
  logic       stk_empty;
  logic [7:0] stk_top;

  sr_shadow_stack u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (sr_cur),
    .top   (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign req = rst ? pick_req(irq_enter, irq_exit, wr_en, alu_valid) : REQ_NONE;

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    sr_next = sr_cur & SR_WR_MASK;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    case (req)
      REQ_IRQ_ENTER: begin
        push               = !stk_full;
        ovf_set            = stk_full;
        sr_next[SR_IE_BIT] = 1'b0;
        sr_next[SR_S_BIT]  = 1'b1;
      end
      REQ_IRQ_EXIT: begin
        if (stk_empty) begin
          unf_set = 1'b1;
        end else begin
          pop     = 1'b1;
          sr_next = stk_top & SR_WR_MASK;
        end
      end
      REQ_WRITE: begin
        if (sr_cur[SR_S_BIT]) begin
          sr_next = wr_data & SR_WR_MASK;
        end else begin
          // User mode may only touch the arithmetic flags.
          sr_next = (sr_cur & SR_WR_MASK & ~SR_USER_WR_MASK) |
                    (wr_data & SR_USER_WR_MASK);
        end
      end
      REQ_ALU: begin
        if (flag_mask[SR_C_BIT]) sr_next[SR_C_BIT] = alu_carry;
        if (flag_mask[SR_Z_BIT]) sr_next[SR_Z_BIT] = (alu_result == 8'h00);
        if (flag_mask[SR_N_BIT]) sr_next[SR_N_BIT] = alu_result[7];
        if (flag_mask[SR_V_BIT]) sr_next[SR_V_BIT] = alu_ovf;
      end
      default: ;
    endcase

    if (!rst) begin
      sr_next = SR_RESET_VAL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      // A fresh error in the same cycle as err_clr wins.
      stk_ovf <= ovf_set | (stk_ovf & ~err_clr);
      stk_unf <= unf_set | (stk_unf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_sr_update_ctrl.sv
// Self-checking bench for sr_update_ctrl: a reference model pushes expected
// results into a scoreboard that is popped when the DUT outputs are sampled.
module tb_sr_update_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sr_cur;
  logic       alu_valid;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_ovf;
  logic [3:0] flag_mask;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       irq_enter;
  logic       irq_exit;
  logic       err_clr;
  logic [7:0] sr_next;
  logic [2:0] stk_depth;
  logic       stk_ovf;
  logic       stk_unf;

  always #5 clk = ~clk;

  sr_update_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .sr_cur     (sr_cur),
    .alu_valid  (alu_valid),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .flag_mask  (flag_mask),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .irq_enter  (irq_enter),
    .irq_exit   (irq_exit),
    .err_clr    (err_clr),
    .sr_next    (sr_next),
    .stk_depth  (stk_depth),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf)
  );

  typedef struct {
    string      tag;
    logic [7:0] sr;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_stack[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    alu_valid  = 1'b0;
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    flag_mask  = 4'h0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    irq_enter  = 1'b0;
    irq_exit   = 1'b0;
    err_clr    = 1'b0;
  endtask

  // Reference model: expected sr_next this cycle and state after the edge.
  task automatic model(input string tag);
    exp_t       e;
    logic [7:0] s;
    logic       new_ovf;
    logic       new_unf;
    new_ovf = 1'b0;
    new_unf = 1'b0;
    if (!rst) begin
      s = 8'h20;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (irq_enter) begin
        s = {2'b00, 2'b10, sr_cur[3:0]};
        if (m_stack.size() == 4) new_ovf = 1'b1;
        else m_stack.push_back(sr_cur);
      end else if (irq_exit) begin
        if (m_stack.size() > 0) s = m_stack.pop_back() & 8'h3F;
        else begin
          s = sr_cur & 8'h3F;
          new_unf = 1'b1;
        end
      end else if (wr_en) begin
        s = sr_cur[5] ? {2'b00, wr_data[5:0]} : {2'b00, sr_cur[5:4], wr_data[3:0]};
      end else if (alu_valid) begin
        s = {2'b00, sr_cur[5:0]};
        if (flag_mask[0]) s[0] = alu_carry;
        if (flag_mask[1]) s[1] = (alu_result == 8'h00);
        if (flag_mask[2]) s[2] = alu_result[7];
        if (flag_mask[3]) s[3] = alu_ovf;
      end else begin
        s = {2'b00, sr_cur[5:0]};
      end
      if (err_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      m_ovf = m_ovf | new_ovf;
      m_unf = m_unf | new_unf;
    end
    e.tag   = tag;
    e.sr    = s;
    e.depth = 3'(m_stack.size());
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb.push_back(e);
  endtask

  // Inputs are already driven; check combinational sr_next mid-cycle, then
  // the registered stack state just after the rising edge.
  task automatic step(input string tag);
    exp_t e;
    model(tag);
    #3;
    e = sb.pop_front();
    check({e.tag, ".sr_next"}, sr_next, e.sr);
    @(posedge clk);
    #1;
    check({e.tag, ".depth"}, {5'b0, stk_depth}, {5'b0, e.depth});
    check({e.tag, ".ovf"}, {7'b0, stk_ovf}, {7'b0, e.ovf});
    check({e.tag, ".unf"}, {7'b0, stk_unf}, {7'b0, e.unf});
  endtask

  initial begin
    rst    = 1'b0;
    sr_cur = 8'h00;
    clear_req();
    step("reset0");
    irq_enter = 1'b1;
    step("reset_ignores_req");
    clear_req();
    rst = 1'b1;

    // ALU flag updates with different masks and operands.
    sr_cur = 8'h30; alu_valid = 1'b1; alu_result = 8'h00; alu_carry = 1'b1; flag_mask = 4'hF;
    step("alu_full_mask");
    alu_result = 8'h80; alu_carry = 1'b0; alu_ovf = 1'b1; flag_mask = 4'b0100; sr_cur = 8'h13;
    step("alu_n_only");
    alu_result = 8'h7F; alu_carry = 1'b1; alu_ovf = 1'b1; flag_mask = 4'b1010; sr_cur = 8'hC6;
    step("alu_vz_reserved");
    clear_req();

    // Explicit writes and priority over ALU.
    sr_cur = 8'h01; wr_en = 1'b1; wr_data = 8'hFF;
    step("wr_user");
    sr_cur = 8'h21; wr_data = 8'hFF; alu_valid = 1'b1; flag_mask = 4'hF;
    step("wr_super_beats_alu");
    sr_cur = 8'h10; wr_data = 8'hE5;
    step("wr_user_keeps_ie");
    clear_req();
    sr_cur = 8'hFF;
    step("hold_masked");

    // Five nested entries: fill then overflow.
    irq_enter = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sr_cur = 8'h30 | 8'(i);
      step($sformatf("enter%0d", i));
    end
    clear_req();
    err_clr = 1'b1;
    step("clr_ovf");
    clear_req();
    irq_exit = 1'b1;
    sr_cur = 8'h20;
    for (int i = 0; i < 4; i++) step($sformatf("exit%0d", i));
    sr_cur = 8'hE5;
    step("exit_underflow");
    clear_req();
    err_clr = 1'b1;
    step("clr_unf");
    clear_req();

    // Two nested entries then three returns.
    irq_enter = 1'b1;
    sr_cur = 8'h31; step("nest_a");
    sr_cur = 8'h25; step("nest_b");
    clear_req();
    irq_exit = 1'b1;
    sr_cur = 8'h20; step("ret_b");
    step("ret_a");
    sr_cur = 8'h14; step("ret_unf");
    clear_req();

    // Simultaneous requests: only the push happens.
    irq_enter = 1'b1; sr_cur = 8'h3F; err_clr = 1'b1;
    step("pre_push");
    irq_exit = 1'b1; wr_en = 1'b1; wr_data = 8'h00; err_clr = 1'b0; sr_cur = 8'h1B;
    step("triple_req");
    clear_req();
    irq_enter = 1'b1;
    sr_cur = 8'h22; step("fill3");
    sr_cur = 8'h23; step("fill4");
    sr_cur = 8'h24; step("ovf_again");
    clear_req();
    irq_exit = 1'b1; sr_cur = 8'h20;
    step("pop_to3");

    // Reset mid-sequence discards the stack and clears flags.
    rst = 1'b0; irq_enter = 1'b1;
    step("rst_mid");
    clear_req();
    rst = 1'b1;
    irq_enter = 1'b1;
    sr_cur = 8'h13; step("first_after_rst");
    sr_cur = 8'h02; step("refill2");
    sr_cur = 8'h03; step("refill3");
    sr_cur = 8'h04; step("refill4");
    err_clr = 1'b1; sr_cur = 8'h05;
    step("clr_with_ovf");
    clear_req();
    err_clr = 1'b1;
    step("clr_alone");
    clear_req();
    irq_exit = 1'b1; sr_cur = 8'h20;
    step("pop_after_rst");
    clear_req();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
